// File: rtl/cp0_regfile_if.sv
// CP0 register file port bundle: MTC0 write, MFC0 read,
// exception/ERET commit and interrupt request.
interface cp0_regfile_if;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_badvaddr_valid;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  ext_int;
    logic        int_req;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        output exc_valid, exc_code, exc_pc, exc_bd,
        output exc_badvaddr_valid, exc_badvaddr,
        output eret, ext_int,
        input  rd_data, int_req, status, cause, epc
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  exc_valid, exc_code, exc_pc, exc_bd,
        input  exc_badvaddr_valid, exc_badvaddr,
        input  eret, ext_int,
        output rd_data, int_req, status, cause, epc
    );
endinterface

// File: rtl/cp0_regfile.sv
// Architectural CP0 state: Status/Cause/EPC/BadVAddr,
// Count/Compare timer, exception entry and ERET.
module cp0_regfile #(
    parameter int unsigned COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic         clk,
    input  logic         resetn,
    cp0_regfile_if.slave bus
);
    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    logic [31:0]   status_q, status_d;
    logic [31:0]   cause_q, cause_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   badva_q, badva_d;
    logic [DW-1:0] div_q, div_d;

    logic wr_ok, tick, ti_d;
    logic wr_status, wr_cause, wr_count, wr_compare, wr_epc;

    // Exception and ERET outrank an MTC0 committed in the same cycle
    assign wr_ok      = bus.wr_en & ~bus.exc_valid & ~bus.eret;
    assign wr_status  = wr_ok & (bus.wr_addr == 5'd12);
    assign wr_cause   = wr_ok & (bus.wr_addr == 5'd13);
    assign wr_count   = wr_ok & (bus.wr_addr == 5'd9);
    assign wr_compare = wr_ok & (bus.wr_addr == 5'd11);
    assign wr_epc     = wr_ok & (bus.wr_addr == 5'd14);
    assign tick       = (div_q == DIV_LAST);

    always_comb begin
        div_d     = tick ? '0 : div_q + DW'(1);
        count_d   = wr_count ? bus.wr_data : count_q + {31'b0, tick};
        compare_d = wr_compare ? bus.wr_data : compare_q;
        ti_d      = ~wr_compare & (cause_q[30] | (count_q == compare_q));
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = wr_epc ? bus.wr_data : epc_q;
        badva_d   = badva_q;
        if (wr_status)
            status_d = (status_q & ~STATUS_WMASK) | (bus.wr_data & STATUS_WMASK);
        if (wr_cause)
            cause_d = (cause_q & ~CAUSE_WMASK) | (bus.wr_data & CAUSE_WMASK);
        if (bus.exc_valid) begin
            // Nested exception keeps the original return point
            if (!status_q[1]) begin
                epc_d      = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                cause_d[31] = bus.exc_bd;
            end
            cause_d[6:2] = bus.exc_code;
            status_d[1]  = 1'b1;
            if (bus.exc_badvaddr_valid)
                badva_d = bus.exc_badvaddr;
        end else if (bus.eret) begin
            status_d[1] = 1'b0;
        end
        cause_d[30]    = ti_d;
        cause_d[15:10] = {bus.ext_int[5] | ti_d, bus.ext_int[4:0]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q  <= STATUS_RESET;
            cause_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            epc_q     <= '0;
            badva_q   <= '0;
            div_q     <= '0;
        end else begin
            status_q  <= status_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
            div_q     <= div_d;
        end
    end

    always_comb begin
        case (bus.rd_addr)
            5'd8:    bus.rd_data = badva_q;
            5'd9:    bus.rd_data = count_q;
            5'd11:   bus.rd_data = compare_q;
            5'd12:   bus.rd_data = status_q;
            5'd13:   bus.rd_data = cause_q;
            5'd14:   bus.rd_data = epc_q;
            default: bus.rd_data = '0;
        endcase
    end

    assign bus.int_req = status_q[0] & ~status_q[1]
                       & |(cause_q[15:8] & status_q[15:8]);
    assign bus.status  = status_q;
    assign bus.cause   = cause_q;
    assign bus.epc     = epc_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expected register
// values are queued at stimulus time and checked by MFC0 reads.
module tb_cp0_regfile;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   edges;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    cp0_regfile_if bus();

    cp0_regfile #(
        .COUNT_DIV(2),
        .STATUS_RESET(32'h0040_0000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; Count ticks on even-numbered edges
    always @(posedge clk or negedge resetn) begin
        if (!resetn) edges <= 0;
        else         edges <= edges + 1;
    end

    task automatic push(input string n, input logic [4:0] a,
                        input logic [31:0] e);
        sb.push_back('{name: n, addr: a, exp: e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic raise(input logic [31:0] pc, input logic bd,
                         input logic [4:0] code, input logic bv,
                         input logic [31:0] va);
        bus.exc_valid          = 1'b1;
        bus.exc_pc             = pc;
        bus.exc_bd             = bd;
        bus.exc_code           = code;
        bus.exc_badvaddr_valid = bv;
        bus.exc_badvaddr       = va;
        cyc();
        bus.exc_valid          = 1'b0;
        bus.exc_badvaddr_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        push("rst_status", 5'd12, 32'h0040_0000);
        push("rst_cause", 5'd13, 32'h0);
        push("rst_count", 5'd9, 32'h0);
        push("rst_unmapped", 5'd3, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        checks++;
        if (bus.int_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_int_req: got %b want 0", bus.int_req);
        end
    endtask

    task automatic test_masks();
        exp_t e;
        mtc0(5'd11, 32'h8000_0000);
        mtc0(5'd12, 32'hFFFF_FFFF);
        push("mask_status", 5'd12, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        push("mask_cause", 5'd13, 32'h0000_0300);
        push("mask_compare", 5'd11, 32'h8000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        checks++;
        if (bus.int_req !== 1'b0) begin
            errors++;
            $display("FAIL mask_int_req_exl: got %b want 0", bus.int_req);
        end
    endtask

    task automatic test_timer();
        exp_t e;
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd8);
        if (edges % 2 == 0) cyc();
        mtc0(5'd9, 32'd5);
        repeat (5) cyc();
        push("tmr_count7", 5'd9, 32'd7);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        push("tmr_count8", 5'd9, 32'd8);
        push("tmr_cause_noti", 5'd13, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        push("tmr_cause_ti", 5'd13, 32'h4000_8000);
        push("tmr_status", 5'd12, 32'h0040_8001);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        checks++;
        if (bus.int_req !== 1'b1) begin
            errors++;
            $display("FAIL tmr_int_req_set: got %b want 1", bus.int_req);
        end
        // Compare write lands while Count still equals Compare
        mtc0(5'd11, 32'h0000_0100);
        push("tmr_cause_clr", 5'd13, 32'h0);
        push("tmr_compare", 5'd11, 32'h0000_0100);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        checks++;
        if (bus.int_req !== 1'b0) begin
            errors++;
            $display("FAIL tmr_int_req_clr: got %b want 0", bus.int_req);
        end
    endtask

    task automatic test_exception();
        exp_t e;
        raise(32'hBFC0_0100, 1'b1, 5'd4, 1'b1, 32'h13);
        push("exc_epc", 5'd14, 32'hBFC0_00FC);
        push("exc_cause", 5'd13, 32'h8000_0010);
        push("exc_badva", 5'd8, 32'h13);
        push("exc_status", 5'd12, 32'h0040_8003);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        checks++;
        if (bus.epc !== 32'hBFC0_00FC || bus.int_req !== 1'b0) begin
            errors++;
            $display("FAIL exc_ports: got epc %h int %b want bfc000fc 0",
                     bus.epc, bus.int_req);
        end
        raise(32'h0000_1234, 1'b0, 5'd5, 1'b0, 32'hFFFF_FFFF);
        mtc0(5'd8, 32'h0000_DEAD);
        push("exc2_epc_hold", 5'd14, 32'hBFC0_00FC);
        push("exc2_cause", 5'd13, 32'h8000_0014);
        push("exc2_badva_hold", 5'd8, 32'h13);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        bus.eret = 1'b1;
        cyc();
        bus.eret = 1'b0;
        push("pri_eret1", 5'd12, 32'h0040_8001);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        bus.eret    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd12;
        bus.wr_data = 32'h0;
        raise(32'h0000_2000, 1'b0, 5'd8, 1'b0, 32'h0);
        bus.eret    = 1'b0;
        bus.wr_en   = 1'b0;
        push("pri_status", 5'd12, 32'h0040_8003);
        push("pri_epc", 5'd14, 32'h0000_2000);
        push("pri_cause", 5'd13, 32'h0000_0020);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        bus.eret = 1'b1;
        cyc();
        bus.eret = 1'b0;
        checks++;
        if (bus.status !== 32'h0040_8001) begin
            errors++;
            $display("FAIL pri_eret2: got %h want 00408001", bus.status);
        end
    endtask

    task automatic test_count_wrap();
        exp_t e;
        if (edges % 2 == 0) cyc();
        mtc0(5'd9, 32'hFFFF_FFFF);
        cyc();
        push("wrap_hold", 5'd9, 32'hFFFF_FFFF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        push("wrap_zero", 5'd9, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        mtc0(5'd9, 32'h10);
        push("wr_beats_tick", 5'd9, 32'h10);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        push("phase_hold", 5'd9, 32'h10);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        push("phase_tick", 5'd9, 32'h11);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
    endtask

    task automatic test_ext_int();
        exp_t e;
        bus.ext_int = 6'h21;
        push("ext_latency", 5'd13, 32'h0000_0020);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.rd_data !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, bus.rd_data, e.exp);
            end
        end
        cyc();
        checks++;
        if (bus.cause !== 32'h0000_8420 || bus.int_req !== 1'b1) begin
            errors++;
            $display("FAIL ext_sample: got cause %h int %b want 00008420 1",
                     bus.cause, bus.int_req);
        end
        bus.ext_int = 6'h0;
        cyc();
        checks++;
        if (bus.cause !== 32'h0000_0020 || bus.int_req !== 1'b0) begin
            errors++;
            $display("FAIL ext_release: got cause %h int %b want 00000020 0",
                     bus.cause, bus.int_req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        bus.exc_valid = 1'b0;
        bus.exc_code = '0;
        bus.exc_pc = '0;
        bus.exc_bd = 1'b0;
        bus.exc_badvaddr_valid = 1'b0;
        bus.exc_badvaddr = '0;
        bus.eret = 1'b0;
        bus.ext_int = '0;
        #21;
        resetn = 1'b1;
        test_reset();
        test_masks();
        test_timer();
        test_exception();
        test_priority();
        test_count_wrap();
        test_ext_int();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Architectural CP0 state holder; the consumer end of the MTC0/MFC0 decode path.
- Decode supplies a register address and a pre-merged write value. This block commits the write, keeps Count/Compare timer state, and records exception entry and ERET.
- Exports read data for MFC0 and an interrupt request to the exception logic.
- Sits beside the writeback stage. Writes and exception events arrive there already resolved.

Parameters:
- COUNT_DIV, 2: clock cycles per Count increment; must be ≥1.
- STATUS_RESET, 32'h0040_0000: Status reset value (BEV=1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  commit an MTC0 this cycle.
- wr_addr  in  5  CP0 register number (8, 9, 11, 12, 13, 14).
- wr_data  in  32  value to write; this block re-applies the write mask.
- rd_addr  in  5  MFC0 read register number.
- rd_data  out  32  combinational read of the current registered value.
- exc_valid  in  1  exception commit this cycle.
- exc_code  in  5  ExcCode.
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a branch delay slot.
- exc_badvaddr_valid  in  1  load BadVAddr on this exception.
- exc_badvaddr  in  32  faulting address.
- eret  in  1  ERET commit.
- ext_int  in  6  hardware interrupt lines, level-sensitive.
- int_req  out  1  pending enabled interrupt.
- status, cause, epc  out  32 each  current register values.

Behaviour:
- Reset (async, resetn=0):
  - Status=STATUS_RESET.
  - Cause, Count, Compare, EPC, BadVAddr = 0.
  - Divider phase = 0; int_req=0.
  - Reset mid-operation discards any pending update; first post-reset edge behaves as reset state.
- Write masks (bits outside the mask hold their value):
  - Status: [15:8] IM, [1] EXL, [0] IE.
  - Cause: [9:8] only.
  - Count, Compare, EPC: all 32 bits.
  - BadVAddr, and any other address: write ignored.
- Read:
  - rd_data reflects the registers as of the last edge; no write bypass.
  - Unmapped rd_addr returns 0.
  - Cause[15:10] reads the registered ext_int sample, with IP7 included.
- Count:
  - Divider counts 0..COUNT_DIV-1; Count increments by 1 when the divider wraps.
  - Count is 32-bit and wraps 0xFFFF_FFFF→0.
  - An MTC0 to Count wins over an increment in the same cycle; divider phase is unaffected.
- Timer:
  - TI=Cause[30] sets on the edge after registered Count==Compare.
  - TI stays set until an MTC0 to Compare, which clears TI. The clear wins if it coincides with a match.
- Interrupt lines:
  - Cause[15:10] ← {ext_int[5]|TI, ext_int[4:0]}, sampled every cycle with one cycle latency.
  - int_req = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), computed from registered values.
- Exception commit (exc_valid=1), on the next edge:
  - If Status.EXL==0: EPC ← exc_bd ? exc_pc−4 : exc_pc, and Cause.BD[31] ← exc_bd.
  - If EXL was already 1: EPC and BD hold.
  - Always: Cause[6:2] ← exc_code; Status.EXL ← 1.
  - BadVAddr ← exc_badvaddr only when exc_badvaddr_valid.
- ERET: Status.EXL ← 0.
- Priority within one cycle: exc_valid > eret > wr_en.
  - The losers' effects on the same register fields are discarded.
  - Count increment, the ext_int sample and the TI set still apply.

Test Plan:
- Reset, then read addr 12, 13, 9 → 0x0040_0000, 0, 0; int_req=0.
- MTC0 Status=0xFFFF_FFFF → Status reads 0x0040_FF03. MTC0 Cause=0xFFFF_FFFF → Cause[9:8]=3, all other Cause bits 0.
- Count=5, Compare=8, COUNT_DIV=2 → Count reaches 8 after 6 cycles; TI=1 and Cause[15]=1 on the next edge. With Status=0x8001, int_req rises. MTC0 Compare=0x100 → TI=0, int_req=0.
- exc_valid, exc_pc=0xBFC0_0100, exc_bd=1, code=4, badvaddr=0x13 valid → EPC=0xBFC0_00FC, Cause[31]=1, ExcCode=4, BadVAddr=0x13, EXL=1. A second exception with EXL set → EPC unchanged.
- exc_valid, eret and wr_en to Status all in the same cycle → EXL=1 and the Status write is dropped. eret alone afterwards → EXL=0.
- Count=0xFFFF_FFFF, let it tick → 0. MTC0 Count=0x10 on a tick cycle → reads 0x10.
